// File: rtl/sata_tx_align_scheduler_pkg.sv
// Shared SATA TX definitions: primitive dwords and scheduler state encoding.
package sata_tx_align_scheduler_pkg;

    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5_957C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

endpackage

// File: rtl/sata_tx_align_scheduler_interval_counter.sv
// Counts accepted link dwords and flags the dword that completes an ALIGN interval.
module sata_tx_align_scheduler_interval_counter #(
    parameter int unsigned ALIGN_INTERVAL = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(ALIGN_INTERVAL);

    logic [15:0] cnt;
    logic [15:0] cnt_inc;

    assign cnt_inc = cnt + 16'd1;
    assign expire  = inc && (cnt_inc == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/sata_tx_align_scheduler.sv
// Shares the PHY TX dword slot between link-layer data and periodic/on-demand ALIGN bursts.
module sata_tx_align_scheduler
    import sata_tx_align_scheduler_pkg::*;
#(
    parameter int unsigned ALIGN_INTERVAL = 256,
    parameter int unsigned ALIGN_BURST    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phy_ready,
    input  logic        align_req,
    input  logic [31:0] link_tx_dout,
    input  logic        link_tx_is_k,
    output logic        link_tx_ready,
    output logic [31:0] tx_dout,
    output logic        tx_is_k,
    output logic        align_active,
    output logic [15:0] align_burst_count
);

    localparam logic [3:0] BURST_LAST = 4'(ALIGN_BURST - 1);

    state_t      state, state_next;
    logic [3:0]  burst_cnt, burst_next;
    logic        req_pending, pending_next;
    logic [31:0] dout_next;
    logic        is_k_next;
    logic        active_next;
    logic [15:0] bcount_next;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        interval_expire;

    assign link_tx_ready = (state == ST_DATA) && phy_ready && !rst;

    sata_tx_align_scheduler_interval_counter #(
        .ALIGN_INTERVAL(ALIGN_INTERVAL)
    ) u_interval (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .expire(interval_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            burst_cnt         <= '0;
            req_pending       <= 1'b0;
            tx_dout           <= PRIM_ALIGN;
            tx_is_k           <= 1'b1;
            align_active      <= 1'b0;
            align_burst_count <= '0;
        end else begin
            state             <= state_next;
            burst_cnt         <= burst_next;
            req_pending       <= pending_next;
            tx_dout           <= dout_next;
            tx_is_k           <= is_k_next;
            align_active      <= active_next;
            align_burst_count <= bcount_next;
        end
    end

    always_comb begin
        state_next   = state;
        burst_next   = burst_cnt;
        pending_next = req_pending;
        dout_next    = PRIM_ALIGN;
        is_k_next    = 1'b1;
        active_next  = 1'b0;
        bcount_next  = align_burst_count;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;

        if (!phy_ready) begin
            // Losing the PHY abandons any partial burst without counting it.
            state_next   = ST_IDLE;
            burst_next   = '0;
            pending_next = 1'b0;
            cnt_clr      = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next   = ST_ALIGN;
                    burst_next   = '0;
                    pending_next = 1'b0;
                    cnt_clr      = 1'b1;
                end
                ST_ALIGN: begin
                    active_next = 1'b1;
                    if (burst_cnt == BURST_LAST) begin
                        bcount_next  = align_burst_count + 16'd1;
                        burst_next   = '0;
                        pending_next = 1'b0;
                        // Any request seen during this burst buys exactly one more burst.
                        state_next   = (req_pending || align_req) ? ST_ALIGN : ST_DATA;
                    end else begin
                        burst_next = burst_cnt + 4'd1;
                        if (align_req) begin
                            pending_next = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    dout_next = link_tx_dout;
                    is_k_next = link_tx_is_k;
                    cnt_inc   = 1'b1;
                    if (interval_expire || req_pending || align_req) begin
                        state_next   = ST_ALIGN;
                        pending_next = 1'b0;
                        cnt_clr      = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sata_tx_align_scheduler.md
Name: sata_tx_align_scheduler

Overview:
- Sits between the link layer TX path and the PHY TX mux. Owns the transmit dword slot once the PHY is ready.
- Shares the slot between link-layer dwords and mandatory ALIGN primitive bursts: periodic every ALIGN_INTERVAL dwords, plus on-demand via align_req.
- Back-pressures the link layer with link_tx_ready while ALIGNs are on the wire.

Parameters:
- ALIGN_INTERVAL, 256: link dwords transmitted between ALIGN bursts; legal range 2..65535.
- ALIGN_BURST, 2: consecutive ALIGN dwords per burst; legal range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- phy_ready  input  1  PHY link up and aligned; low forces the ALIGN-only output.
- align_req  input  1  single-cycle pulse requesting an extra ALIGN burst at the next dword boundary.
- link_tx_dout  input  32  link-layer dword.
- link_tx_is_k  input  1  link-layer dword is a K-character primitive.
- link_tx_ready  output  1  link dword consumed this cycle (combinational).
- tx_dout  output  32  registered dword to PHY.
- tx_is_k  output  1  registered K flag to PHY.
- align_active  output  1  registered; high while tx_dout carries a scheduled ALIGN.
- align_burst_count  output  16  number of completed ALIGN bursts; wraps at 16'hFFFF->0.

Behaviour:
- Reset values: tx_dout=PRIM_ALIGN, tx_is_k=1, align_active=0, align_burst_count=0, state=IDLE, dword counter=0, burst counter=0, req_pending=0.
- link_tx_ready = (state==DATA) && phy_ready && !rst. It is purely combinational.
- Latency: a dword accepted at edge N appears on tx_dout/tx_is_k after edge N (1 cycle).
- States:
  - IDLE:
    - Drive tx_dout=PRIM_ALIGN, tx_is_k=1, align_active=0.
    - Clear the dword counter and req_pending.
    - phy_ready=1 -> ALIGN.
  - ALIGN:
    - Drive PRIM_ALIGN, K=1, align_active=1, one dword per cycle.
    - Burst counter increments each cycle.
    - After ALIGN_BURST dwords -> DATA. At that transition align_burst_count++ and the burst counter clears.
  - DATA:
    - Each cycle with link_tx_ready: tx_dout<=link_tx_dout, tx_is_k<=link_tx_is_k, align_active<=0, dword counter++.
    - When the accepted dword makes the counter equal ALIGN_INTERVAL, or req_pending is set, or align_req is high this cycle: next state ALIGN and the counter clears.
    - The current dword is still transmitted; the burst starts on the following edge.
- The first burst after phy_ready rises is counted in align_burst_count.
- align_req handling:
  - Received in IDLE or ALIGN: sets req_pending only if in ALIGN. It is serviced by one extra burst immediately after the current burst (ALIGN -> ALIGN, counter restart).
  - Multiple pulses before service collapse into one burst.
  - align_req coinciding with interval expiry produces a single burst, not two.
- phy_ready low in any state: the next edge enters IDLE and outputs PRIM_ALIGN/K=1. No link dword is accepted that cycle (ready already low). A partially sent burst is abandoned and not counted.
- rst mid-burst or mid-data: all state returns to reset values on that edge.
- Counter widths: dword counter 16 bits, burst counter 4 bits. Compare with == only; no overflow is possible within the legal parameter range.

Decomposition:
- Shared package/defines (existing sata_defines): PRIM_ALIGN, PRIM_SYNC, state encodings (IDLE, ALIGN, DATA as 2-bit localparams).
- No sub-module needed. The optional natural split is sata_align_interval_counter (dword counter + expiry compare), instantiated once.

Test Plan:
- Reset then phy_ready=1 with link_tx_dout incrementing from 0 -> tx_dout shows ALIGN,ALIGN, then 0..255, then ALIGN,ALIGN, then 256. link_tx_ready is low exactly 2 of every 258 cycles, and align_burst_count=2 after the second burst.
- ALIGN_INTERVAL=4, ALIGN_BURST=1 -> pattern ALIGN,d0,d1,d2,d3,ALIGN,d4… with no dword dropped or duplicated.
- align_req pulse after dword 10 is accepted (interval 256) -> dword 10 is transmitted, then 2 ALIGNs, then dword 11. The interval counter restarts, so the next periodic burst follows dword 266.
- align_req asserted on the same cycle the 256th dword is accepted -> exactly one 2-dword burst.
- phy_ready drops mid-DATA and again mid-ALIGN -> tx_dout=PRIM_ALIGN/K=1 on the next cycle and link_tx_ready=0 immediately. On return a fresh burst is sent and the abandoned burst is not counted.
- rst asserted mid-burst with align_burst_count=5 -> next cycle tx_dout=PRIM_ALIGN, align_active=0, align_burst_count=0, state IDLE.
